conv_out_collector: RTL and testbench

Consumer of the 5x5 convolution output stream. Takes the per-clock conv result plus the qualifying `valid` strobe (28 valid / 4 invalid per 32-cycle row), packs the valid samples into a dense OUT_SIZE x OUT_SIZE raster, and issues one write per sample to the output feature-map memory. Signals frame completion and flags stream anomalies.

---
 rtl/conv_out_collector.sv | 131 +++++++++++++
 tb/tb_conv_out_collector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/conv_out_collector.sv
// Packs the valid samples of the conv output stream into a dense OUT_SIZE x OUT_SIZE raster of memory writes.
// Optional run/gap pattern checker: define CONV_COLLECT_CHECK_EN to enable err_gap.
module conv_out_collector #(
  parameter int OUT_SIZE = 28,
  parameter int IMG_SIZE = 32,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              err_gap
);

  localparam int CW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [CW-1:0]     LAST_IDX = CW'(OUT_SIZE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(OUT_SIZE);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t state, state_nxt;
  logic [CW-1:0]     col, row;
  logic [ADDR_W-1:0] base;
  logic              restart, accept, last, stray;

  always_comb begin
    restart = start && (state != DONE);
    accept  = (state == COLLECT) && in_valid && !start;
    last    = accept && (row == LAST_IDX) && (col == LAST_IDX);
    stray   = in_valid && (((state == IDLE) && !start) || (state == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (start) state_nxt = COLLECT;
               else if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == COLLECT);

  // base tracks row*OUT_SIZE so the address needs only an adder
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      col        <= '0;
      row        <= '0;
      base       <= '0;
    end else begin
      wr_en      <= accept;
      frame_done <= last;
      if (accept) begin
        wr_data <= in_data;
        wr_addr <= base + ADDR_W'(col);
        if (col == LAST_IDX) begin
          col  <= '0;
          row  <= row + CW'(1);
          base <= base + ROW_STEP;
        end else begin
          col <= col + CW'(1);
        end
      end
      if (restart) begin
        col      <= '0;
        row      <= '0;
        base     <= '0;
        overflow <= 1'b0;
      end else if (stray) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef CONV_COLLECT_CHECK_EN
  localparam int RW = $clog2(OUT_SIZE + 2);
  localparam int GW = $clog2(IMG_SIZE + 2);

  logic [RW-1:0] run_len;
  logic [GW-1:0] gap_len;
  logic          had_run;

  // gap is only judged between two runs, so leading idle never trips it
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      run_len <= '0;
      gap_len <= '0;
      had_run <= 1'b0;
      err_gap <= 1'b0;
    end else if (state == COLLECT) begin
      if (in_valid) begin
        if (had_run && (gap_len != '0) && (gap_len != GW'(IMG_SIZE - OUT_SIZE)))
          err_gap <= 1'b1;
        gap_len <= '0;
        if (run_len == RW'(OUT_SIZE)) err_gap <= 1'b1;
        else                          run_len <= run_len + RW'(1);
      end else begin
        if (run_len != '0) begin
          had_run <= 1'b1;
          if (run_len != RW'(OUT_SIZE)) err_gap <= 1'b1;
        end
        run_len <= '0;
        if (gap_len != GW'(IMG_SIZE)) gap_len <= gap_len + GW'(1);
      end
    end
  end
`else
  assign err_gap = 1'b0;
`endif

endmodule

// File: tb/tb_conv_out_collector.sv
// Self-checking bench for conv_out_collector: table vectors, directed frames and randomized traffic vs a sample-count model.
module tb_conv_out_collector;
  localparam int OUT = 28, IMG = 32, DW = 16, AW = 10, NS = OUT * OUT;
`ifdef CONV_COLLECT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic wr_en, busy, frame_done, overflow, err_gap;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  conv_out_collector #(.OUT_SIZE(OUT), .IMG_SIZE(IMG), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .overflow(overflow), .err_gap(err_gap));

  always #5 clk = ~clk;

  int n_pass = 0, n_chk = 0;
  // model: mode 0 idle, 1 collecting, 2 done; m_n = samples accepted this frame
  int m_mode = 0, m_n = 0, run = 0, gap = 0;
  bit m_ovf = 0, m_err = 0, had = 0;
  bit e_we = 0, e_fd = 0, e_rst = 0;
  int e_addr = 0, e_data = 0;
  int obs_wr = 0, obs_fd = 0, fd_addr = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic m_restart();
    m_mode = 1; m_n = 0; m_ovf = 0; m_err = 0; run = 0; gap = 0; had = 0;
  endtask

  task automatic model_edge(input bit r, input bit s, input bit v, input int d);
    e_we = 0; e_fd = 0; e_rst = r;
    if (r) begin
      m_mode = 0; m_n = 0; m_ovf = 0; m_err = 0; run = 0; gap = 0; had = 0;
      e_addr = 0; e_data = 0;
    end else begin
      case (m_mode)
        0: if (s) m_restart(); else if (v) m_ovf = 1;
        1: if (s) m_restart();
           else begin
             if (CHK) begin
               if (v) begin
                 if (had && gap > 0 && gap != IMG - OUT) m_err = 1;
                 gap = 0; run++;
                 if (run > OUT) m_err = 1;
               end else begin
                 if (run > 0) begin had = 1; if (run != OUT) m_err = 1; end
                 run = 0; gap++;
               end
             end
             if (v) begin
               e_we = 1; e_addr = m_n; e_data = d; m_n++;
               if (m_n == NS) begin m_mode = 2; e_fd = 1; end
             end
           end
        default: begin m_mode = 0; if (v) m_ovf = 1; end
      endcase
    end
  endtask

  task automatic step(input bit r, input bit s, input bit v, input logic [DW-1:0] d);
    rst = r; start = s; in_valid = v; in_data = d;
    @(posedge clk);
    model_edge(r, s, v, int'(d));
    #1;
    chk("wr_en", int'(wr_en), int'(e_we));
    chk("busy", int'(busy), int'(m_mode == 1));
    chk("frame_done", int'(frame_done), int'(e_fd));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("err_gap", int'(err_gap), int'(m_err));
    if (e_we || e_rst) begin
      chk("wr_addr", int'(wr_addr), e_addr);
      chk("wr_data", int'(wr_data), e_data);
    end
    if (wr_en) obs_wr++;
    if (frame_done) begin obs_fd++; fd_addr = int'(wr_addr); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, DW'($urandom));
  endtask

  typedef struct {
    bit r, s, v; logic [DW-1:0] d;
    bit x_we; int x_addr; int x_data; bit x_busy; bit x_ovf;
  } vec_t;
  vec_t tv[11];

  initial begin
    tv[0]  = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 0, 1, 16'h1111, 0, 0, 0, 0, 1};
    tv[2]  = '{0, 1, 1, 16'h2222, 0, 0, 0, 1, 0};
    tv[3]  = '{0, 0, 1, 16'hA001, 1, 0, 16'hA001, 1, 0};
    tv[4]  = '{0, 0, 0, 16'hFFFF, 0, 0, 0, 1, 0};
    tv[5]  = '{0, 0, 1, 16'hB002, 1, 1, 16'hB002, 1, 0};
    tv[6]  = '{0, 0, 1, 16'hC003, 1, 2, 16'hC003, 1, 0};
    tv[7]  = '{0, 1, 1, 16'h5555, 0, 0, 0, 1, 0};
    tv[8]  = '{0, 0, 1, 16'hD004, 1, 0, 16'hD004, 1, 0};
    tv[9]  = '{1, 0, 1, 16'h7777, 0, 0, 0, 0, 0};
    tv[10] = '{0, 0, 1, 16'h8888, 0, 0, 0, 0, 1};

    for (int i = 0; i < 11; i++) begin
      step(tv[i].r, tv[i].s, tv[i].v, tv[i].d);
      chk($sformatf("tv%0d_we", i), int'(wr_en), int'(tv[i].x_we));
      chk($sformatf("tv%0d_busy", i), int'(busy), int'(tv[i].x_busy));
      chk($sformatf("tv%0d_ovf", i), int'(overflow), int'(tv[i].x_ovf));
      if (tv[i].x_we || tv[i].r) begin
        chk($sformatf("tv%0d_addr", i), int'(wr_addr), tv[i].x_addr);
        chk($sformatf("tv%0d_data", i), int'(wr_data), tv[i].x_data);
      end
    end

    // patterned frame with leading idle
    step(0, 1, 0, '0);
    obs_wr = 0; obs_fd = 0; fd_addr = -1;
    idle(132);
    for (int r = 0; r < OUT; r++) begin samples(OUT); idle(IMG - OUT); end
    chk("pat_writes", obs_wr, NS);
    chk("pat_fd_count", obs_fd, 1);
    chk("pat_fd_addr", fd_addr, NS - 1);
    chk("pat_err", int'(err_gap), 0);

    // continuous frame, then stray samples after the last address
    step(0, 1, 0, '0);
    obs_wr = 0;
    samples(29);
    chk("cont_err29", int'(err_gap), int'(CHK));
    samples(NS - 29);
    chk("cont_writes", obs_wr, NS);
    samples(3);
    chk("extra_writes", obs_wr, NS);
    chk("extra_ovf", int'(overflow), 1);
    step(0, 1, 0, '0);
    chk("start_clr_ovf", int'(overflow), 0);

    // reset mid-frame, then samples without start
    samples(100);
    step(1, 0, 1, 16'hBEEF);
    chk("rst_we", int'(wr_en), 0);
    obs_wr = 0;
    samples(5);
    chk("post_rst_writes", obs_wr, 0);
    chk("post_rst_ovf", int'(overflow), 1);

    // restart after 50 samples
    step(0, 1, 0, '0);
    samples(50);
    step(0, 1, 1, 16'h1234);
    obs_wr = 0; obs_fd = 0;
    step(0, 0, 1, 16'h4321);
    chk("restart_addr", int'(wr_addr), 0);
    samples(NS - 1);
    chk("restart_writes", obs_wr, NS);
    chk("restart_fd", obs_fd, 1);

    // short row followed by a long gap: flag only, collection continues
    step(0, 1, 0, '0);
    samples(OUT); idle(IMG - OUT);
    samples(OUT - 1); idle(IMG - OUT + 1);
    chk("short_row_err", int'(err_gap), int'(CHK));
    for (int g = 0; g < 2000 && m_mode == 1; g++) begin
      if ((g % IMG) < OUT) step(0, 0, 1, DW'($urandom)); else step(0, 0, 0, '0);
    end
    chk("short_row_done", m_mode, 0);

    // randomized traffic
    for (int i = 0; i < 6000; i++)
      step($urandom_range(0, 2999) == 0, $urandom_range(0, 1499) == 0,
           $urandom_range(0, 3) != 0, DW'($urandom));
    step(0, 1, 0, '0);
    for (int i = 0; i < 1500; i++)
      step(0, 0, (i % IMG) < OUT || $urandom_range(0, 9) == 0, DW'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
